// File: rtl/conv1d_sram_pkg.sv
// Shared SRAM port types and helpers for the conv1d accelerator.
// Default-width request/response structs; width-generic variants live in the modules.
package conv1d_sram_pkg;

  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SRAM_ADDR_W = 32;

  typedef struct packed {
    logic                     req;
    logic                     we;
    logic [SRAM_DATA_W/8-1:0] be;
    logic [SRAM_ADDR_W-1:0]   addr;
    logic [SRAM_DATA_W-1:0]   wdata;
  } sram_req_t;

  typedef struct packed {
    logic                   rvalid;
    logic [SRAM_DATA_W-1:0] rdata;
  } sram_rsp_t;

  // Index width that stays at least one bit wide for a single channel.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv1d_rr_arbiter.sv
// NumCh-wide round-robin arbiter: one-hot grant, winner index, pointer register.
// With CONV1D_SRAM_ARB_PRIO_EN defined, channel 0 has strict priority over the rotating rest.
module conv1d_rr_arbiter
  import conv1d_sram_pkg::*;
#(
  parameter int unsigned NumCh = 3,
  parameter int unsigned IdxW  = clog2_min1(NumCh)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] req_i,
  output logic [NumCh-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

`ifdef CONV1D_SRAM_ARB_PRIO_EN
  localparam bit PrioEn = 1'b1;
`else
  localparam bit PrioEn = 1'b0;
`endif

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic            found;
  int unsigned     sum;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    sum   = 0;
    if (PrioEn && req_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
    for (int unsigned i = 0; i < NumCh; i++) begin
      sum = 32'(ptr_q) + i;
      if (sum >= NumCh) sum = sum - NumCh;
      cand = IdxW'(sum);
      // In priority mode channel 0 is handled above and never part of the rotation.
      if (!found && req_i[cand] && !(PrioEn && (cand == '0))) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && !(PrioEn && (idx_o == '0))) begin
      ptr_d = (32'(idx_o) == NumCh - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/conv1d_sram_arb.sv
// N-channel round-robin arbiter onto one fixed-latency SRAM port with response routing.
// Optional CONV1D_SRAM_ARB_PRIO_EN gives channel 0 strict priority (see conv1d_rr_arbiter).
module conv1d_sram_arb
  import conv1d_sram_pkg::*;
#(
  parameter int unsigned NumCh     = 3,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned RdLatency = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumCh-1:0]                 ch_req_i,
  input  logic [NumCh-1:0]                 ch_we_i,
  input  logic [NumCh*(DataWidth/8)-1:0]   ch_be_i,
  input  logic [NumCh*AddrWidth-1:0]       ch_addr_i,
  input  logic [NumCh*DataWidth-1:0]       ch_wdata_i,
  output logic [NumCh-1:0]                 ch_gnt_o,
  output logic [NumCh-1:0]                 ch_rvalid_o,
  output logic [DataWidth-1:0]             ch_rdata_o,
  output logic                             sram_req_o,
  output logic                             sram_we_o,
  output logic [DataWidth/8-1:0]           sram_be_o,
  output logic [AddrWidth-1:0]             sram_addr_o,
  output logic [DataWidth-1:0]             sram_wdata_o,
  input  logic [DataWidth-1:0]             sram_rdata_i
);

  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned IdxW = clog2_min1(NumCh);

  typedef struct packed {
    logic                 we;
    logic [BeW-1:0]       be;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
  } ch_req_t;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [IdxW-1:0] id;
  } rsp_tag_t;

  logic [NumCh-1:0] arb_gnt;
  logic [IdxW-1:0]  win_idx;
  ch_req_t          ch_req [NumCh];
  ch_req_t          win_req;
  rsp_tag_t         pipe_d;
  rsp_tag_t         pipe_q [RdLatency];
  rsp_tag_t         tail;

  conv1d_rr_arbiter #(
    .NumCh (NumCh),
    .IdxW  (IdxW)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (ch_req_i),
    .gnt_o  (arb_gnt),
    .idx_o  (win_idx)
  );

  for (genvar k = 0; k < NumCh; k++) begin : g_ch
    assign ch_req[k].we    = ch_we_i[k];
    assign ch_req[k].be    = ch_be_i[k*BeW +: BeW];
    assign ch_req[k].addr  = ch_addr_i[k*AddrWidth +: AddrWidth];
    assign ch_req[k].wdata = ch_wdata_i[k*DataWidth +: DataWidth];
    assign ch_rvalid_o[k]  = tail.valid && (tail.id == IdxW'(k));
  end

  // Grants are masked while reset is asserted so nothing reaches the SRAM.
  assign ch_gnt_o   = arb_gnt & {NumCh{rst_ni}};
  assign sram_req_o = |ch_gnt_o;
  assign win_req    = sram_req_o ? ch_req[win_idx] : '0;

  assign sram_we_o    = win_req.we;
  assign sram_be_o    = win_req.be;
  assign sram_addr_o  = win_req.addr;
  assign sram_wdata_o = win_req.wdata;

  assign pipe_d.valid = sram_req_o;
  assign pipe_d.we    = win_req.we;
  assign pipe_d.id    = win_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RdLatency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_d;
      for (int i = 1; i < RdLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail       = pipe_q[RdLatency-1];
  assign ch_rdata_o = (tail.valid && !tail.we) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_conv1d_sram_arb.sv
// Self-checking bench for conv1d_sram_arb: grant table, directed SRAM sequences,
// random mixed traffic against a queue-based reference model, and mid-run reset.
module tb_conv1d_sram_arb;
  localparam int NUM_CH = 3;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int RD_LAT = 2;
  localparam int BEW    = DW / 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       ch_req, ch_we, gnt, rvalid;
  logic [NUM_CH*BEW-1:0]   ch_be;
  logic [NUM_CH*AW-1:0]    ch_addr;
  logic [NUM_CH*DW-1:0]    ch_wdata;
  logic [DW-1:0]           rdata, sram_rdata, sram_wdata;
  logic                    sram_req, sram_we;
  logic [BEW-1:0]          sram_be;
  logic [AW-1:0]           sram_addr;

  always #5 clk = ~clk;

  conv1d_sram_arb #(
    .NumCh(NUM_CH), .DataWidth(DW), .AddrWidth(AW), .RdLatency(RD_LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_be_i(ch_be), .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata),
    .ch_gnt_o(gnt), .ch_rvalid_o(rvalid), .ch_rdata_o(rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_be_o(sram_be), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 'h10 / 4) return 32'hAAAA_AAAA;
    if (i == 'h40 / 4) return 32'hDEAD_BEEF;
    return (i * 32'h0101_0101) ^ 32'h5A5A_A5A5;
  endfunction

  // SRAM macro: fixed read latency, byte-masked writes, read-before-write.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (sram_req && sram_we) begin
      for (int b = 0; b < BEW; b++)
        if (sram_be[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    rd_pipe[0] <= sram_req ? mem[sram_addr[9:2]] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  // Reference model state
  typedef struct { int due; int ch; bit we; logic [DW-1:0] data; } rsp_t;
  rsp_t          rsp_q[$];
  logic [DW-1:0] ref_mem [256];
  int            rr_next;
  int            cyc;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pick(logic [NUM_CH-1:0] req);
`ifdef CONV1D_SRAM_ARB_PRIO_EN
    if (req[0]) return 0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      c = (rr_next + i) % NUM_CH;
`ifdef CONV1D_SRAM_ARB_PRIO_EN
      if (c == 0) continue;
`endif
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic eval_cycle(output int w);
    logic [NUM_CH-1:0] eg, erv;
    logic [DW-1:0]     erd;
    int                word;
    w  = model_pick(ch_req);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("sram_req", 64'(sram_req), 64'(w >= 0));
    if (w >= 0) begin
      chk("sram_we", 64'(sram_we), 64'(ch_we[w]));
      chk("sram_be", 64'(sram_be), 64'(ch_be[w*BEW +: BEW]));
      chk("sram_addr", 64'(sram_addr), 64'(ch_addr[w*AW +: AW]));
      chk("sram_wdata", 64'(sram_wdata), 64'(ch_wdata[w*DW +: DW]));
    end else begin
      chk("idle_ctl", 64'({sram_we, sram_be, sram_addr}), 64'd0);
      chk("idle_wdata", 64'(sram_wdata), 64'd0);
    end
    erv = '0;
    erd = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      rsp_t r;
      r = rsp_q.pop_front();
      erv[r.ch] = 1'b1;
      erd = r.we ? '0 : r.data;
    end
    chk("rvalid", 64'(rvalid), 64'(erv));
    chk("rdata", 64'(rdata), 64'(erd));
    if (w >= 0) begin
      word = int'(ch_addr[w*AW+2 +: 8]);
      rsp_q.push_back('{due: cyc + RD_LAT, ch: w, we: ch_we[w], data: ref_mem[word]});
      if (ch_we[w])
        for (int b = 0; b < BEW; b++)
          if (ch_be[w*BEW+b]) ref_mem[word][8*b +: 8] = ch_wdata[w*DW+8*b +: 8];
`ifdef CONV1D_SRAM_ARB_PRIO_EN
      if (w != 0) rr_next = (w + 1) % NUM_CH;
`else
      rr_next = (w + 1) % NUM_CH;
`endif
    end
  endtask

  // Inputs are set at a falling edge; outputs sampled 1ns later; returns at next falling edge.
  task automatic cycle(output int w);
    #1;
    eval_cycle(w);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_ch(int c, bit rq, bit we, logic [BEW-1:0] be, logic [AW-1:0] addr, logic [DW-1:0] wd);
    ch_req[c] = rq;
    ch_we[c]  = we;
    ch_be[c*BEW +: BEW]  = be;
    ch_addr[c*AW +: AW]  = addr;
    ch_wdata[c*DW +: DW] = wd;
  endtask

  task automatic single(string name, int c, bit we, logic [BEW-1:0] be, logic [AW-1:0] addr,
                        logic [DW-1:0] wd, logic [DW-1:0] exp_rd);
    int w;
    bit got;
    got = 1'b0;
    set_ch(c, 1'b1, we, be, addr, wd);
    for (int t = 0; t < 20 && !got; t++) begin
      cycle(w);
      if (w == c) got = 1'b1;
    end
    chk({name, "_granted"}, 64'(got), 64'd1);
    ch_req[c] = 1'b0;
    repeat (RD_LAT - 1) cycle(w);
    #1;
    chk({name, "_rvalid"}, 64'(rvalid), 64'(1 << c));
    chk({name, "_rdata"}, 64'(rdata), 64'(exp_rd));
    cycle(w);
  endtask

  typedef struct { logic [NUM_CH-1:0] req; logic [NUM_CH-1:0] gnt; } vec_t;
  vec_t tbl[6];

  initial begin
    int w, issued, granted;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int w, issued, granted;
`ifdef CONV1D_SRAM_ARB_PRIO_EN
    tbl[0] = '{3'b111, 3'b001}; tbl[1] = '{3'b111, 3'b001}; tbl[2] = '{3'b111, 3'b001};
    tbl[3] = '{3'b110, 3'b010}; tbl[4] = '{3'b110, 3'b100}; tbl[5] = '{3'b110, 3'b010};
`else
    tbl[0] = '{3'b111, 3'b001}; tbl[1] = '{3'b111, 3'b010}; tbl[2] = '{3'b111, 3'b100};
    tbl[3] = '{3'b111, 3'b001}; tbl[4] = '{3'b111, 3'b010}; tbl[5] = '{3'b111, 3'b100};
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rr_next = 0;
    cyc = 0;
    ch_req = '0; ch_we = '0; ch_be = '0; ch_addr = '0; ch_wdata = '0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 1'b0, 4'hF, AW'(32'h100 + 4 * c), '0);

    // Reset with all channels requesting
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_sram_req", 64'(sram_req), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arbitration table
    for (int i = 0; i < 6; i++) begin
      ch_req = tbl[i].req;
      #1;
      chk($sformatf("tbl_gnt[%0d]", i), 64'(gnt), 64'(tbl[i].gnt));
      cycle(w);
    end
    ch_req = '0;
    repeat (RD_LAT + 1) cycle(w);

    // Directed SRAM sequences
    single("rd_ch1_40", 1, 1'b0, 4'hF, 32'h40, 32'h0, 32'hDEAD_BEEF);
    single("wr_ch2_10", 2, 1'b1, 4'b0011, 32'h10, 32'h1234_5678, 32'h0);
    single("rd_ch2_10", 2, 1'b0, 4'hF, 32'h10, 32'h0, 32'hAAAA_5678);
    repeat (2) cycle(w);

    // Random mixed traffic
    issued = 0;
    granted = 0;
    for (int t = 0; t < 3000 && granted < 100; t++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (!ch_req[c] && issued < 100 && $urandom_range(0, 2) != 0) begin
          set_ch(c, 1'b1, 1'($urandom_range(0, 1)), BEW'($urandom()),
                 AW'($urandom_range(0, 255) * 4), DW'($urandom()));
          issued++;
        end
      cycle(w);
      if (w >= 0) begin
        ch_req[w] = 1'b0;
        granted++;
      end
    end
    chk("rand_all_granted", 64'(granted), 64'd100);
    ch_req = '0;
    repeat (RD_LAT + 2) cycle(w);
    chk("rand_rsp_drained", 64'(rsp_q.size()), 64'd0);

    // Reset while responses are in flight
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 1'(c == 1), 4'hF, AW'(32'h200 + 4 * c), DW'(32'hC0DE_0000 + c));
    cycle(w);
    if (w >= 0) ch_req[w] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    cyc++;
    ch_req = '0;
    rsp_q.delete();
    rr_next = 0;
    rst_n = 1'b1;
    repeat (RD_LAT + 2) cycle(w);
    ch_req = 3'b111;
    cycle(w);
    chk("post_rst_first_win", 64'(w), 64'd0);
    ch_req = '0;
    repeat (RD_LAT + 1) cycle(w);
    chk("post_rst_drained", 64'(rsp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
